wb_arbiter2: RTL and testbench
==============================

# wb_arbiter2

Two-master arbiter for the internal 8-bit Wishbone bus. It sits between the bus masters (the parallel-port bus bridge and a second command master, e.g. the UART command path) and the shared slave side, which the top level decodes into per-channel strobes. It serialises transactions with round-robin fairness, routes ack and read data back to the owning master, and optionally aborts transactions that no slave acknowledges.

## Interface
Parameters:
- TIMEOUT, 15: cycles a granted transaction may wait for `s_ack_i` before it is aborted. Legal range is 1..255.

Ports (clock and reset are shared by the whole block):
- clk_i  in  1  system clock; all logic is on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m0_stb_i / m1_stb_i  in  1  master strobe; held until ack.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_adr_i / m1_adr_i  in  8  address.
- m0_dat_i / m1_dat_i  in  8  write data.
- m0_dat_o / m1_dat_o  out  8  read data; valid with ack.
- m0_ack_o / m1_ack_o  out  1  transaction done.
- m0_err_o / m1_err_o  out  1  timeout abort; asserted together with ack.
- s_stb_o  out  1  strobe to the slave decode.
- s_we_o  out  1  write enable to the slaves.
- s_adr_o  out  8  address to the slaves.
- s_dat_o  out  8  write data to the slaves.
- s_dat_i  in  8  read data from the slave mux.
- s_ack_i  in  1  ack from the slave mux.
- grant_o  out  2  one-hot owner; 2'b00 when idle.

## Operation
- Registered state: IDLE, BUSY; `owner` (1 bit); `last` (1 bit, master served last).
- IDLE:
  - No strobe: stay in IDLE.
  - One strobe: BUSY, `owner` = that master.
  - Both strobes: `owner` = !`last`.
- BUSY:
  - `s_stb_o/we/adr/dat` are driven combinationally from the owner's inputs.
  - Non-owner outputs are held at 0.
- BUSY with `s_ack_i` = 1 in a cycle:
  - The owner sees ack = 1 and dat_o = `s_dat_i` in that same cycle.
  - Next state is IDLE; `last` <= `owner`.
- BUSY with owner's stb dropped before ack: abort with no ack. Next state is IDLE; `last` is updated.
- Non-owner strobe during BUSY: ignored, and stays pending until IDLE.
- IDLE drives all slave-side outputs, all master outputs and grant_o to 0.
- Reset:
  - State = IDLE; `last` = 1, so m0 wins the first contention.
  - Timeout counter = 0.
  - Reset during BUSY drops the transaction with no ack.

## Timing
- Grant latency: strobe sampled at edge N gives BUSY from edge N onward; `s_stb_o` goes high in cycle N+1.
- Ack cycle: ack reaches the master combinationally in the cycle `s_ack_i` is high. BUSY ends at the following edge.
- Back-to-back: at least one IDLE cycle separates any two transactions. Pending requests are granted at the edge that leaves that IDLE cycle.
- Master obligation: drop stb in the cycle after ack. A stb still high at IDLE counts as a new request.
- Output reset values: every output is 0.

## Configuration
WB_ARB_TIMEOUT_EN:
- Defined:
  - Counter width: $clog2(TIMEOUT+1) bits. It clears on entering BUSY and increments each BUSY cycle without ack.
  - When it equals TIMEOUT with no ack, the owner gets ack = 1, err = 1 and dat_o = 8'hFF for one cycle. `s_stb_o` is forced to 0 in that cycle.
  - Next state is IDLE; `last` is updated.
  - If `s_ack_i` and the timeout occur in the same cycle, ack wins: normal completion, err = 0.
- Undefined: no counter; err outputs tied to 0; BUSY waits indefinitely.

## Structure
- Shared header, alongside the register definitions: state encodings, ERR_DATA = 8'hFF, default TIMEOUT.
- Sub-module `wb_timeout_cnt` (clear, enable, done), instantiated only under WB_ARB_TIMEOUT_EN.
- Address decoding stays outside this block.

## Test plan
- m0 write, adr 8'h31, dat 8'hA5; slave acks 2 cycles after s_stb_o → s_adr_o = 8'h31, s_dat_o = 8'hA5, s_we_o = 1; m0_ack_o for 1 cycle; m1 outputs 0.
- m0 and m1 strobe in the same cycle after reset, both held → m0 granted first (grant_o = 01), then m1 (grant_o = 10) after one IDLE cycle.
- Five consecutive contended rounds → grants alternate 01, 10, 01, 10, 01.
- m1 read, slave returns 8'h5C with ack → m1_dat_o = 8'h5C in the ack cycle; m0_dat_o = 0.
- With macro and TIMEOUT = 4, slave never acks → at the 4th BUSY cycle without ack: m0_ack_o = 1, m0_err_o = 1, m0_dat_o = 8'hFF. Without macro, grant_o is still 01 after 100 cycles.
- rst_i asserted for 1 cycle mid-BUSY → next cycle grant_o = 0 and s_stb_o = 0, no ack; the next contention grants m0.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter2_pkg
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding,
// the read data returned on a timeout abort, the default timeout, and a helper
// that turns the owner bit into the one-hot grant vector.
// ---------------------------------------------------------------------------
package wb_arbiter2_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Read data presented to a master whose transaction was aborted by timeout.
    localparam logic [7:0] ERR_DATA = 8'hFF;

    localparam int DEFAULT_TIMEOUT = 15;

    // Owner bit to one-hot grant: 0 -> 2'b01 (m0), 1 -> 2'b10 (m1).
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_arbiter2_timeout_cnt.sv
// ---------------------------------------------------------------------------
// wb_timeout_cnt
// Counts BUSY cycles that pass without a slave acknowledge.
// done_o is high in the cycle whose count, including that cycle, reaches
// TIMEOUT; with TIMEOUT = 4 it fires in the 4th un-acked BUSY cycle.
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
//
// Ports:
//   clk_i   system clock (rising edge)
//   rst_i   synchronous active-high reset, clears the count
//   clr_i   clear the count (held while the arbiter is idle)
//   en_i    count this cycle (BUSY and no ack)
//   done_o  timeout reached in the current cycle
// ---------------------------------------------------------------------------
module wb_timeout_cnt
    import wb_arbiter2_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The count is zero in the first BUSY cycle, so the TIMEOUT-th cycle
    // sees TIMEOUT-1 in the register.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear, increment or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_arbiter2.sv
// ---------------------------------------------------------------------------
// wb_arbiter2
// Round-robin arbiter letting two 8-bit Wishbone masters share one slave side.
// A request seen in IDLE is granted at that edge; the owner's cycle signals are
// then passed combinationally to the slave side and ack/read data returned to
// the owner only. Every transaction is followed by at least one IDLE cycle.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a transaction not acknowledged
// within TIMEOUT BUSY cycles is aborted with ack=1, err=1, dat=8'hFF.
// Without the macro err outputs are 0 and BUSY waits for ack indefinitely.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   mX_stb_i/we_i/adr_i/dat_i master X request (X = 0, 1)
//   mX_dat_o/ack_o/err_o     master X response
//   s_stb_o/we_o/adr_o/dat_o  slave-side request
//   s_dat_i, s_ack_i          slave-side response
//   grant_o                   one-hot owner, 2'b00 when idle
// ---------------------------------------------------------------------------
module wb_arbiter2
    import wb_arbiter2_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       m0_stb_i,
    input  logic       m0_we_i,
    input  logic [7:0] m0_adr_i,
    input  logic [7:0] m0_dat_i,
    output logic [7:0] m0_dat_o,
    output logic       m0_ack_o,
    output logic       m0_err_o,
    input  logic       m1_stb_i,
    input  logic       m1_we_i,
    input  logic [7:0] m1_adr_i,
    input  logic [7:0] m1_dat_i,
    output logic [7:0] m1_dat_o,
    output logic       m1_ack_o,
    output logic       m1_err_o,
    output logic       s_stb_o,
    output logic       s_we_o,
    output logic [7:0] s_adr_o,
    output logic [7:0] s_dat_o,
    input  logic [7:0] s_dat_i,
    input  logic       s_ack_i,
    output logic [1:0] grant_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       owner_q;
    logic       owner_d;
    logic       last_q;
    logic       last_d;

    logic       busy_s;
    logic       own_stb_s;
    logic       own_we_s;
    logic [7:0] own_adr_s;
    logic [7:0] own_dat_s;
    logic       tmo_s;
    logic       ack_s;
    logic       err_s;
    logic [7:0] rdat_s;

    // A reset cycle already counts as idle so a transaction caught by reset
    // never sees an ack.
    assign busy_s = (state_q == ST_BUSY) && !rst_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic tmo_clr_s;
    logic tmo_en_s;

    assign tmo_clr_s = (state_q == ST_IDLE);
    assign tmo_en_s  = busy_s && !s_ack_i;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (tmo_clr_s),
        .en_i   (tmo_en_s),
        .done_o (tmo_s)
    );
`else
    logic unused_timeout_s;

    assign tmo_s            = 1'b0;
    assign unused_timeout_s = (TIMEOUT > 0);
`endif

    // Select the current owner's request signals.
    always_comb begin
        own_stb_s = m0_stb_i;
        own_we_s  = m0_we_i;
        own_adr_s = m0_adr_i;
        own_dat_s = m0_dat_i;
        if (owner_q) begin
            own_stb_s = m1_stb_i;
            own_we_s  = m1_we_i;
            own_adr_s = m1_adr_i;
            own_dat_s = m1_dat_i;
        end else begin
            own_stb_s = m0_stb_i;
            own_we_s  = m0_we_i;
            own_adr_s = m0_adr_i;
            own_dat_s = m0_dat_i;
        end
    end

    // Completion: slave ack wins over a coincident timeout; a dropped strobe
    // aborts silently.
    always_comb begin
        ack_s  = busy_s && own_stb_s && (s_ack_i || tmo_s);
        err_s  = ack_s && !s_ack_i;
        rdat_s = s_dat_i;
        if (err_s) begin
            rdat_s = ERR_DATA;
        end else begin
            rdat_s = s_dat_i;
        end
    end

    // Next-state logic: grant in IDLE, return to IDLE on ack, abort or timeout.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_stb_i && m1_stb_i) begin
                    state_d = ST_BUSY;
                    owner_d = !last_q;
                end else if (m0_stb_i) begin
                    state_d = ST_BUSY;
                    owner_d = 1'b0;
                end else if (m1_stb_i) begin
                    state_d = ST_BUSY;
                    owner_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!own_stb_s || s_ack_i || tmo_s) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output steering: everything is 0 unless BUSY, and only the owner sees
    // its response.
    always_comb begin
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = 8'h00;
        s_dat_o  = 8'h00;
        grant_o  = 2'b00;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = 8'h00;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = 8'h00;
        if (busy_s) begin
            s_stb_o = own_stb_s && !tmo_s;
            s_we_o  = own_we_s;
            s_adr_o = own_adr_s;
            s_dat_o = own_dat_s;
            grant_o = owner_onehot(owner_q);
            if (owner_q) begin
                m1_ack_o = ack_s;
                m1_err_o = err_s;
                m1_dat_o = ack_s ? rdat_s : 8'h00;
            end else begin
                m0_ack_o = ack_s;
                m0_err_o = err_s;
                m0_dat_o = ack_s ? rdat_s : 8'h00;
            end
        end else begin
            s_stb_o = 1'b0;
        end
    end

    // State registers; last starts at 1 so m0 wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter2
// Cycle-by-cycle vectors: each record holds the inputs applied for one clock
// cycle and the outputs expected in that same cycle. Inputs change on the
// falling edge and outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_wb_arbiter2;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_stb, m0_we, m1_stb, m1_we, s_ack;
    logic [7:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
    logic [7:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_stb_o, s_we_o;
    logic [1:0] grant_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .m0_stb_i (m0_stb),
        .m0_we_i  (m0_we),
        .m0_adr_i (m0_adr),
        .m0_dat_i (m0_dat),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_stb_i (m1_stb),
        .m1_we_i  (m1_we),
        .m1_adr_i (m1_adr),
        .m1_dat_i (m1_dat),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat),
        .s_ack_i  (s_ack),
        .grant_o  (grant_o)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        m0_stb;
        logic        m0_we;
        logic [7:0]  m0_adr;
        logic [7:0]  m0_dat;
        logic        m1_stb;
        logic        m1_we;
        logic [7:0]  m1_adr;
        logic [7:0]  m1_dat;
        logic        s_ack;
        logic [7:0]  s_dat;
        logic [39:0] exp;
    } vec_t;

    localparam logic [39:0] ZERO = 40'h0;

    // Expected output word:
    // {grant, s_stb, s_we, s_adr, s_dat, m0_ack, m0_err, m0_dat, m1_ack, m1_err, m1_dat}
    function automatic logic [39:0] ex(input logic [1:0] g, input logic sstb, input logic swe,
                                       input logic [7:0] sadr, input logic [7:0] sdat,
                                       input logic a0, input logic e0, input logic [7:0] d0,
                                       input logic a1, input logic e1, input logic [7:0] d1);
        return {g, sstb, swe, sadr, sdat, a0, e0, d0, a1, e1, d1};
    endfunction

    function automatic vec_t mk(input string n, input logic r,
                                input logic s0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                                input logic s1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                                input logic ack, input logic [7:0] sd, input logic [39:0] e);
        vec_t v;
        v.name = n;   v.rst = r;
        v.m0_stb = s0; v.m0_we = w0; v.m0_adr = a0; v.m0_dat = d0;
        v.m1_stb = s1; v.m1_we = w1; v.m1_adr = a1; v.m1_dat = d1;
        v.s_ack = ack; v.s_dat = sd; v.exp = e;
        return v;
    endfunction

    task automatic step(input vec_t v);
        logic [39:0] act;
        @(negedge clk);
        rst    = v.rst;
        m0_stb = v.m0_stb; m0_we = v.m0_we; m0_adr = v.m0_adr; m0_dat = v.m0_dat;
        m1_stb = v.m1_stb; m1_we = v.m1_we; m1_adr = v.m1_adr; m1_dat = v.m1_dat;
        s_ack  = v.s_ack;  s_dat = v.s_dat;
        #1;
        act = {grant_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
               m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o};
        checks++;
        if (act !== v.exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", v.name, act, v.exp);
        end
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 8'h00; m0_dat = 8'h00;
        m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 8'h00; m1_dat = 8'h00;
        s_ack = 1'b0;  s_dat = 8'h00;

        // Reset with both masters requesting: nothing is granted.
        tbl.push_back(mk("rst_a", 1'b1, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h00, ZERO));
        tbl.push_back(mk("rst_b", 1'b1, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h00, ZERO));
        // m0 write 31/A5, slave acks 2 cycles after s_stb_o rises.
        tbl.push_back(mk("wr_idle", 1'b0, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        tbl.push_back(mk("wr_busy1", 1'b0, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                         ex(2'b01, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00)));
        tbl.push_back(mk("wr_busy2", 1'b0, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                         ex(2'b01, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00)));
        tbl.push_back(mk("wr_ack", 1'b0, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h6E,
                         ex(2'b01, 1'b1, 1'b1, 8'h31, 8'hA5, 1'b1, 1'b0, 8'h6E, 1'b0, 1'b0, 8'h00)));
        tbl.push_back(mk("wr_drop", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        // m1 read of 40, slave returns 5C in the first BUSY cycle.
        tbl.push_back(mk("rd_idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h00, ZERO));
        tbl.push_back(mk("rd_ack", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 8'h5C,
                         ex(2'b10, 1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5C)));
        tbl.push_back(mk("rd_drop", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        // Five contended rounds, both strobes held, slave always acking:
        // grants alternate 01,10,01,10,01 with an IDLE cycle between.
        for (int r = 0; r < 5; r++) begin
            tbl.push_back(mk($sformatf("rr_idle%0d", r), 1'b0, 1'b1, 1'b1, 8'h10, 8'h11,
                             1'b1, 1'b0, 8'h20, 8'h22, 1'b1, 8'h99, ZERO));
            if ((r % 2) == 0) begin
                tbl.push_back(mk($sformatf("rr_grant%0d", r), 1'b0, 1'b1, 1'b1, 8'h10, 8'h11,
                                 1'b1, 1'b0, 8'h20, 8'h22, 1'b1, 8'h99,
                                 ex(2'b01, 1'b1, 1'b1, 8'h10, 8'h11, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 8'h00)));
            end else begin
                tbl.push_back(mk($sformatf("rr_grant%0d", r), 1'b0, 1'b1, 1'b1, 8'h10, 8'h11,
                                 1'b1, 1'b0, 8'h20, 8'h22, 1'b1, 8'h99,
                                 ex(2'b10, 1'b1, 1'b0, 8'h20, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h99)));
            end
        end
        tbl.push_back(mk("rr_drop", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        // m1 raises stb while m0 owns the bus: ignored until IDLE, then granted.
        tbl.push_back(mk("pend_idle", 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        tbl.push_back(mk("pend_busy", 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 8'h02, 8'h44, 1'b0, 8'h00,
                         ex(2'b01, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00)));
        tbl.push_back(mk("pend_ack", 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 8'h02, 8'h44, 1'b1, 8'h3C,
                         ex(2'b01, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00)));
        tbl.push_back(mk("pend_idle2", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h02, 8'h44, 1'b0, 8'h00, ZERO));
        tbl.push_back(mk("pend_grant", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h02, 8'h44, 1'b0, 8'h00,
                         ex(2'b10, 1'b1, 1'b1, 8'h02, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00)));
        // m1 drops stb before ack: no ack even though the slave acks.
        tbl.push_back(mk("abort", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h02, 8'h44, 1'b1, 8'h77,
                         ex(2'b10, 1'b0, 1'b1, 8'h02, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00)));
        tbl.push_back(mk("abort_idle", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));

        foreach (tbl[i]) step(tbl[i]);

        // Reset mid-BUSY: first leave last = m0 so that without reset m1
        // would win the following contention.
        step(mk("pre_idle", 1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        step(mk("pre_ack", 1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00,
                ex(2'b01, 1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00)));
        step(mk("pre_idle2", 1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        step(mk("rst_busy", 1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, ZERO));
        step(mk("rst_after", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        step(mk("rst_cont", 1'b0, 1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 8'h00, ZERO));
        step(mk("rst_win", 1'b0, 1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 8'h12,
                ex(2'b01, 1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 8'h00)));
        step(mk("rst_drop", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));

`ifdef WB_ARB_TIMEOUT_EN
        // TIMEOUT = 4, no ack: abort with ack/err/FF in the 4th BUSY cycle.
        step(mk("tmo_idle", 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        for (int c = 1; c <= 3; c++) begin
            step(mk($sformatf("tmo_wait%0d", c), 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                    ex(2'b01, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00)));
        end
        step(mk("tmo_fire", 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                ex(2'b01, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00)));
        step(mk("tmo_drop", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        // Ack arriving in the timeout cycle wins: normal completion.
        step(mk("tie_idle", 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        for (int c = 1; c <= 3; c++) begin
            step(mk($sformatf("tie_wait%0d", c), 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                    ex(2'b01, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00)));
        end
        step(mk("tie_ack", 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h21,
                ex(2'b01, 1'b1, 1'b0, 8'h08, 8'h00, 1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 8'h00)));
        step(mk("tie_drop", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
`else
        // No timeout: the grant holds for 100 un-acked cycles.
        step(mk("hold_idle", 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
        for (int c = 1; c <= 100; c++) begin
            step(mk($sformatf("hold%0d", c), 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00,
                    ex(2'b01, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00)));
        end
        step(mk("hold_ack", 1'b0, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h21,
                ex(2'b01, 1'b1, 1'b0, 8'h08, 8'h00, 1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 8'h00)));
        step(mk("hold_drop", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, ZERO));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
